serial_frame_tx: RTL

// Byte-to-serial framer for the transmitter datapath. Accepts parallel words over a

---
 rtl/serial_frame_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: one-entry holding buffer feeding an LSB-first
// start/data/[parity]/stop framer, with every bit period paced by an external bit strobe.
module serial_frame_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_bit_en,
    input  logic [DATA_BITS-1:0]         i_tx_data,
    input  logic                         i_tx_valid,
    output logic                         o_tx_ready,
    output logic                         o_tx_serial,
    output logic                         o_tx_busy,
    output logic [$clog2(DATA_BITS)-1:0] o_bit_index,
    output logic                         o_frame_done,
    output logic [2:0]                   o_dbg_state
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_buf;
    logic                 r_buf_full;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_serial;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_parity;
    logic [IDX_W-1:0]     w_next_idx;

    // Handshake: a word transfers on any clock edge where i_tx_valid && o_tx_ready; ready
    // means the holding buffer is empty, so a full buffer ignores valid even as it drains.
    assign o_tx_ready = !r_buf_full && !i_reset;
    assign w_accept   = i_tx_valid && o_tx_ready;
    assign w_next_idx = r_bit_idx + 1'b1;
    assign w_parity   = (^r_shift) ^ (PARITY_ODD != 0);

    assign o_tx_serial  = r_serial;
    assign o_tx_busy    = (r_state != S_IDLE);
    assign o_bit_index  = r_bit_idx;
    assign o_frame_done = r_done;
    assign o_dbg_state  = r_state;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_serial   <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_buf      <= i_tx_data;
                r_buf_full <= 1'b1;
            end
            // The line register changes on the same strobe edge as the state, so each bit
            // spans exactly one strobe-to-strobe interval.
            if (i_bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_buf_full) begin
                            r_shift    <= r_buf;
                            r_buf_full <= 1'b0;
                            r_state    <= S_START;
                            r_serial   <= 1'b0;
                        end
                    end
                    S_START: begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_serial  <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_bit_idx  <= '0;
                            r_stop_cnt <= 1'b0;
                            if (PARITY_EN != 0) begin
                                r_state  <= S_PARITY;
                                r_serial <= w_parity;
                            end else begin
                                r_state  <= S_STOP;
                                r_serial <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_serial  <= r_shift[w_next_idx];
                        end
                    end
                    S_PARITY: begin
                        r_state    <= S_STOP;
                        r_stop_cnt <= 1'b0;
                        r_serial   <= 1'b1;
                    end
                    S_STOP: begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_done     <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            // A waiting word goes straight into its start bit: no idle gap.
                            if (r_buf_full) begin
                                r_shift    <= r_buf;
                                r_buf_full <= 1'b0;
                                r_state    <= S_START;
                                r_serial   <= 1'b0;
                            end else begin
                                r_state  <= S_IDLE;
                                r_serial <= 1'b1;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_serial <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
